uart_frame_rx: RTL and testbench

UART_FRAME_RX -- requirements
Module: uart_frame_rx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx.sv | 116 +++++++++++
 rtl/uart_frame_rx.sv | 100 ++++++++++
 tb/tb_uart_frame_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame receiver.
//   rx_state_t         : bit-level receiver FSM states
//   DEF_CLKS_PER_BIT   : default clocks per bit (115200 baud at 100 MHz)
//   DEF_FRAME_BYTES    : default bytes per assembled frame
//   DEF_TIMEOUT_BITS   : default idle bit-times before a partial frame is dropped
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int DEF_FRAME_BYTES  = 20;
  localparam int DEF_TIMEOUT_BITS = 20;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver with a 2-flop input synchronizer.
//   clk        : clock, rising edge
//   reset_n    : synchronous active-low reset
//   i_Rx       : asynchronous serial line, idle high, LSB first
//   o_Rx_Byte  : last byte received with a good stop bit
//   o_Rx_DV    : one-cycle pulse, o_Rx_Byte updated
//   frame_err  : one-cycle pulse, stop bit sampled low
//   byte_done  : combinational, high on the edge that loads o_Rx_Byte
//   byte_data  : combinational, the byte being loaded when byte_done is high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_Rx,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_DV,
  output logic       frame_err,
  output logic       byte_done,
  output logic [7:0] byte_data
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;
  logic             rx_meta;
  logic             rx_sync;

  // Exposed so the frame assembler can act on the same edge that raises
  // o_Rx_DV, keeping its valid pulse aligned with the byte pulse.
  assign byte_done = (state == ST_STOP) && (clk_cnt == FULL_CNT) && rx_sync;
  assign byte_data = shift_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_q   <= '0;
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      o_Rx_Byte <= '0;
      o_Rx_DV   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; every flop samples the
      // pre-edge value of the others, which is what makes the synchronizer
      // a true two-stage chain rather than a wire.
      rx_meta   <= i_Rx;
      rx_sync   <= rx_meta;
      o_Rx_DV   <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_sync) state <= ST_START;
        end

        // Re-check the line half a bit in; a short low glitch returns to
        // idle silently.
        ST_START: begin
          if (clk_cnt == HALF_CNT) begin
            clk_cnt <= '0;
            state   <= rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (clk_cnt == FULL_CNT) begin
            clk_cnt <= '0;
            shift_q <= {rx_sync, shift_q[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (clk_cnt == FULL_CNT) begin
            clk_cnt <= '0;
            if (rx_sync) begin
              o_Rx_Byte <= shift_q;
              o_Rx_DV   <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_WAIT_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        // A held break must go high before another start bit is accepted.
        ST_WAIT_IDLE: begin
          if (rx_sync) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// UART receiver that assembles fixed-length frames of bytes.
//   clk          : clock, rising edge
//   reset_n      : synchronous active-low reset
//   i_Rx         : asynchronous serial line, idle high, 8N1, LSB first
//   o_Rx_Byte    : last correctly received byte
//   o_Rx_DV      : one-cycle pulse, o_Rx_Byte updated
//   dataOut      : last complete frame, first byte in the top 8 bits
//   valid        : one-cycle pulse, dataOut updated (same cycle as o_Rx_DV)
//   frame_err    : one-cycle pulse, stop bit sampled low
//   timeout_err  : one-cycle pulse, partial frame discarded after idle time
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FRAME_BYTES  = DEF_FRAME_BYTES,
  parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_Rx,
  output logic [7:0]               o_Rx_Byte,
  output logic                     o_Rx_DV,
  output logic [8*FRAME_BYTES-1:0] dataOut,
  output logic                     valid,
  output logic                     frame_err,
  output logic                     timeout_err
);

  localparam int FRAME_W        = 8 * FRAME_BYTES;
  localparam int BYTE_W         = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int IDLE_W         = $clog2(TIMEOUT_CYCLES);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(FRAME_BYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic               byte_done;
  logic [7:0]         byte_data;
  logic [BYTE_W-1:0]  byte_cnt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [FRAME_W-1:0] asm_q;
  logic [FRAME_W-1:0] asm_next;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_Rx      (i_Rx),
    .o_Rx_Byte (o_Rx_Byte),
    .o_Rx_DV   (o_Rx_DV),
    .frame_err (frame_err),
    .byte_done (byte_done),
    .byte_data (byte_data)
  );

  // Older bytes move toward the MSB, so the first byte of a frame ends up
  // in the top 8 bits once the frame is complete.
  assign asm_next = {asm_q[FRAME_W-9:0], byte_data};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      byte_cnt    <= '0;
      idle_cnt    <= '0;
      asm_q       <= '0;
      dataOut     <= '0;
      valid       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      valid       <= 1'b0;
      timeout_err <= 1'b0;

      if (frame_err) begin
        byte_cnt <= '0;
        idle_cnt <= '0;
      end else if (byte_done) begin
        // A byte arriving on the terminal idle count wins over the timeout.
        idle_cnt <= '0;
        asm_q    <= asm_next;
        if (byte_cnt == LAST_BYTE) begin
          byte_cnt <= '0;
          dataOut  <= asm_next;
          valid    <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end else if (byte_cnt != '0) begin
        if (idle_cnt == IDLE_LAST) begin
          byte_cnt    <= '0;
          idle_cnt    <= '0;
          timeout_err <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed testbench for uart_frame_rx. A short bit period keeps whole
// frames within a small cycle budget; timing expectations scale with it.
module tb_uart_frame_rx;
  import uart_pkg::*;

  localparam int CPB = 16;
  localparam int FB  = 20;
  localparam int TB  = 20;
  localparam int FW  = 8 * FB;
  // Start-bit falling edge to o_Rx_DV: 2 synchronizer edges, 1 edge to
  // enter START, half bit plus one, then 8 data bits and the stop bit.
  localparam int DV_LATENCY = 3 + (CPB - 1) / 2 + 1 + 9 * CPB;
  localparam int TMO_LATENCY = TB * CPB;

  localparam logic [FW-1:0] FRAME_A = 160'h0102030405060708090A0B0C0D0E0F1011121314;
  localparam logic [FW-1:0] FRAME_B = 160'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF00010203;
  localparam logic [FW-1:0] FRAME_C = 160'h404142434445464748494A4B4C4D4E4F50515253;
  localparam logic [FW-1:0] FRAME_D = 160'h606162636465666768696A6B6C6D6E6F70717273;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_Rx = 1'b1;
  logic [7:0]    o_Rx_Byte;
  logic          o_Rx_DV;
  logic [FW-1:0] dataOut;
  logic          valid;
  logic          frame_err;
  logic          timeout_err;

  always #5 clk = ~clk;

  uart_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .FRAME_BYTES (FB),
    .TIMEOUT_BITS(TB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_Rx       (i_Rx),
    .o_Rx_Byte  (o_Rx_Byte),
    .o_Rx_DV    (o_Rx_DV),
    .dataOut    (dataOut),
    .valid      (valid),
    .frame_err  (frame_err),
    .timeout_err(timeout_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Pulse monitor, sampled on the falling edge.
  int dv_n = 0, valid_n = 0, ferr_n = 0, tmo_n = 0, valid_wo_dv = 0;
  int last_dv_cyc = 0, last_tmo_cyc = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (o_Rx_DV) begin
        dv_n++;
        last_dv_cyc = cyc;
      end
      if (valid) valid_n++;
      if (valid && !o_Rx_DV) valid_wo_dv++;
      if (frame_err) ferr_n++;
      if (timeout_err) begin
        tmo_n++;
        last_tmo_cyc = cyc;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int last_start_cyc = 0;

  // All stimulus tasks start and end on a falling edge.
  task automatic idle_bits(input int bits);
    i_Rx = 1'b1;
    repeat (bits * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    i_Rx = 1'b0;
    last_start_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_Rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    i_Rx = stop_bit;
    repeat (CPB) @(negedge clk);
    i_Rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] first);
    logic [7:0] b;
    b = first;
    for (int i = 0; i < FB; i++) begin
      send_byte(b, 1'b1);
      b = b + 8'd1;
    end
  endtask

  int dv0, valid0, ferr0, tmo0;
  task automatic snap();
    dv0 = dv_n; valid0 = valid_n; ferr0 = ferr_n; tmo0 = tmo_n;
  endtask

  initial begin
    logic [7:0] part;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_byte", FW'(o_Rx_Byte), '0);
    check("rst_dv", FW'(o_Rx_DV), '0);
    check("rst_dataout", dataOut, '0);
    check("rst_valid", FW'(valid), '0);
    check("rst_ferr", FW'(frame_err), '0);
    check("rst_tmo", FW'(timeout_err), '0);
    reset_n = 1'b1;
    idle_bits(2);

    // Short low glitch is rejected
    snap();
    i_Rx = 1'b0;
    repeat (5) @(negedge clk);
    idle_bits(3);
    check("glitch_dv", FW'(dv_n - dv0), '0);
    check("glitch_ferr", FW'(ferr_n - ferr0), '0);
    check("glitch_byte", FW'(o_Rx_Byte), '0);

    // Single byte, then timeout of the one-byte partial frame
    snap();
    send_byte(8'hA5, 1'b1);
    idle_bits(1);
    check("a5_dv_count", FW'(dv_n - dv0), FW'(1));
    check("a5_byte", FW'(o_Rx_Byte), FW'(8'hA5));
    check("a5_dv_latency", FW'(last_dv_cyc - last_start_cyc), FW'(DV_LATENCY));
    check("a5_no_valid", FW'(valid_n - valid0), '0);
    idle_bits(21);
    check("a5_tmo_count", FW'(tmo_n - tmo0), FW'(1));
    check("a5_tmo_latency", FW'(last_tmo_cyc - last_dv_cyc), FW'(TMO_LATENCY));

    // Back-to-back frame 0x01..0x14, then long idle with no timeout
    snap();
    send_frame(8'h01);
    idle_bits(25);
    check("fa_dv_count", FW'(dv_n - dv0), FW'(FB));
    check("fa_valid_count", FW'(valid_n - valid0), FW'(1));
    check("fa_dataout", dataOut, FRAME_A);
    check("fa_ferr", FW'(ferr_n - ferr0), '0);
    check("fa_tmo", FW'(tmo_n - tmo0), '0);
    check("valid_aligned", FW'(valid_wo_dv), '0);

    // Two good bytes, then a bad stop bit; counter must restart
    snap();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h05, 1'b0);
    idle_bits(2);
    check("ferr_count", FW'(ferr_n - ferr0), FW'(1));
    check("ferr_no_valid", FW'(valid_n - valid0), '0);
    check("ferr_byte_kept", FW'(o_Rx_Byte), FW'(8'h22));
    check("ferr_dataout_held", dataOut, FRAME_A);
    snap();
    send_frame(8'hF0);
    idle_bits(2);
    check("fb_valid_count", FW'(valid_n - valid0), FW'(1));
    check("fb_dataout", dataOut, FRAME_B);
    check("fb_tmo", FW'(tmo_n - tmo0), '0);

    // Seven bytes, then timeout; dataOut untouched until the next frame
    snap();
    for (int i = 0; i < 7; i++) send_byte(8'h30 + 8'(i), 1'b1);
    idle_bits(21);
    check("tmo_count", FW'(tmo_n - tmo0), FW'(1));
    check("tmo_latency", FW'(last_tmo_cyc - last_dv_cyc), FW'(TMO_LATENCY));
    check("tmo_no_valid", FW'(valid_n - valid0), '0);
    check("tmo_dataout_held", dataOut, FRAME_B);
    snap();
    send_frame(8'h40);
    idle_bits(2);
    check("fc_valid_count", FW'(valid_n - valid0), FW'(1));
    check("fc_dataout", dataOut, FRAME_C);

    // Reset during bit 3 of byte 10
    for (int i = 0; i < 9; i++) send_byte(8'h90 + 8'(i), 1'b1);
    part = 8'h99;
    i_Rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      i_Rx = part[i];
      repeat (CPB) @(negedge clk);
    end
    i_Rx = part[3];
    repeat (CPB / 2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_byte", FW'(o_Rx_Byte), '0);
    check("mid_rst_dataout", dataOut, '0);
    check("mid_rst_pulses", FW'({o_Rx_DV, valid, frame_err, timeout_err}), '0);
    reset_n = 1'b1;
    snap();
    idle_bits(24);
    check("post_rst_quiet", FW'((dv_n - dv0) + (ferr_n - ferr0) + (tmo_n - tmo0)), '0);
    send_frame(8'h60);
    idle_bits(2);
    check("fd_valid_count", FW'(valid_n - valid0), FW'(1));
    check("fd_dataout", dataOut, FRAME_D);
    check("fd_ferr", FW'(ferr_n - ferr0), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
